// File: rtl/pool_pkg.sv
// Shared types and elaboration helpers for the max-pooling window scheduler.
package pool_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        OUT,
        FIN
    } pool_state_t;

    function automatic int out_dim(int in_sz, int p, int f, int s);
        return (in_sz + 2 * p - f) / s + 1;
    endfunction

    // Counter width that never collapses to zero bits for a size of one.
    function automatic int cnt_w(int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic longint SMIN(int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/pool_window_sched_if.sv
// Handshake bundle between the pooling scheduler, its feature buffer and the downstream stream.
interface pool_window_sched_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int ROW_W  = 2,
    parameter int COL_W  = 2
);
    logic                     start;
    logic                     busy;
    logic                     done;
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [DATA_W-1:0] rd_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic [ROW_W-1:0]         out_row;
    logic [COL_W-1:0]         out_col;

    modport master (
        input  start, rd_data, out_ready,
        output busy, done, rd_en, rd_addr, out_valid, out_data, out_row, out_col
    );

    modport slave (
        output start, rd_data, out_ready,
        input  busy, done, rd_en, rd_addr, out_valid, out_data, out_row, out_col
    );
endinterface

// File: rtl/pool_addr_gen.sv
// Window walker: output-position and kernel-element counters, padding check and
// linear feature-buffer address for the element currently being issued.
module pool_addr_gen
    import pool_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int IN_H   = 8,
    parameter int F_W    = 2,
    parameter int F_H    = 2,
    parameter int S      = 2,
    parameter int P      = 0,
    parameter int ADDR_W = $clog2(IN_W * IN_H),
    parameter int ROW_W  = cnt_w(out_dim(IN_H, P, F_H, S)),
    parameter int COL_W  = cnt_w(out_dim(IN_W, P, F_W, S))
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_step,
    input  logic              i_next_win,
    output logic              o_in_range,
    output logic              o_last_elem,
    output logic              o_last_win,
    output logic [ADDR_W-1:0] o_addr,
    output logic [ROW_W-1:0]  o_oy,
    output logic [COL_W-1:0]  o_ox
);
    localparam int OUT_W = out_dim(IN_W, P, F_W, S);
    localparam int OUT_H = out_dim(IN_H, P, F_H, S);
    localparam int KX_W  = cnt_w(F_W);
    localparam int KY_W  = cnt_w(F_H);

    logic [KX_W-1:0]  r_kx;
    logic [KY_W-1:0]  r_ky;
    logic [COL_W-1:0] r_ox;
    logic [ROW_W-1:0] r_oy;

    logic signed [31:0] w_iy;
    logic signed [31:0] w_ix;
    logic               w_kx_last;
    logic               w_ky_last;
    logic               w_ox_last;
    logic               w_oy_last;

    // Input coordinates may go negative inside the padding border.
    assign w_iy = $signed(32'(r_oy)) * S + $signed(32'(r_ky)) - P;
    assign w_ix = $signed(32'(r_ox)) * S + $signed(32'(r_kx)) - P;

    assign w_kx_last = (r_kx == KX_W'(F_W - 1));
    assign w_ky_last = (r_ky == KY_W'(F_H - 1));
    assign w_ox_last = (r_ox == COL_W'(OUT_W - 1));
    assign w_oy_last = (r_oy == ROW_W'(OUT_H - 1));

    assign o_in_range  = (w_iy >= 0) && (w_iy < IN_H) && (w_ix >= 0) && (w_ix < IN_W);
    assign o_addr      = ADDR_W'(w_iy * IN_W + w_ix);
    assign o_last_elem = w_kx_last && w_ky_last;
    assign o_last_win  = w_ox_last && w_oy_last;
    assign o_oy        = r_oy;
    assign o_ox        = r_ox;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_kx <= '0;
            r_ky <= '0;
            r_ox <= '0;
            r_oy <= '0;
        end else begin
            // Kernel counters wrap by themselves so the next window starts at (0,0).
            if (i_step) begin
                if (w_kx_last) begin
                    r_kx <= '0;
                    r_ky <= w_ky_last ? '0 : r_ky + KY_W'(1);
                end else begin
                    r_kx <= r_kx + KX_W'(1);
                end
            end
            if (i_next_win) begin
                if (w_ox_last) begin
                    r_ox <= '0;
                    r_oy <= w_oy_last ? '0 : r_oy + ROW_W'(1);
                end else begin
                    r_ox <= r_ox + COL_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pool_window_sched.sv
// Max-pooling scheduler: walks one channel window by window, reads each element from the
// feature buffer, reduces to a signed maximum and emits one result per window.
module pool_window_sched
    import pool_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IN_W   = 8,
    parameter int IN_H   = 8,
    parameter int F_W    = 2,
    parameter int F_H    = 2,
    parameter int S      = 2,
    parameter int P      = 0,
    parameter int ADDR_W = $clog2(IN_W * IN_H)
) (
    input logic               clk,
    input logic               rst,
    pool_window_sched_if.master bus
);
    localparam int OUT_W = out_dim(IN_W, P, F_W, S);
    localparam int OUT_H = out_dim(IN_H, P, F_H, S);
    localparam int ROW_W = cnt_w(OUT_H);
    localparam int COL_W = cnt_w(OUT_W);
    localparam logic signed [DATA_W-1:0] ACC_INIT = DATA_W'(SMIN(DATA_W));

    if (S < 1 || P >= F_W || P >= F_H) begin : g_param_check
        $error("pool_window_sched: need S>=1, P<F_W and P<F_H");
    end

    pool_state_t              r_state;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_out_valid;
    logic                     r_tag;
    logic signed [DATA_W-1:0] r_acc;
    logic signed [DATA_W-1:0] r_out_data;
    logic [ROW_W-1:0]         r_out_row;
    logic [COL_W-1:0]         r_out_col;

    logic                     w_in_range;
    logic                     w_last_elem;
    logic                     w_last_win;
    logic [ADDR_W-1:0]        w_addr;
    logic [ROW_W-1:0]         w_oy;
    logic [COL_W-1:0]         w_ox;
    logic                     w_start_ok;
    logic                     w_rd_en;
    logic                     w_accept;
    logic signed [DATA_W-1:0] w_acc_next;

    assign w_start_ok = (r_state == IDLE) && bus.start;
    assign w_rd_en    = (r_state == ISSUE) && w_in_range;
    assign w_accept   = (r_state == OUT) && bus.out_ready;
    // Ties keep the accumulator; untagged cycles never touch it.
    assign w_acc_next = (r_tag && (bus.rd_data > r_acc)) ? bus.rd_data : r_acc;

    pool_addr_gen #(
        .IN_W   (IN_W),
        .IN_H   (IN_H),
        .F_W    (F_W),
        .F_H    (F_H),
        .S      (S),
        .P      (P),
        .ADDR_W (ADDR_W),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_start_ok),
        .i_step      (r_state == ISSUE),
        .i_next_win  (w_accept),
        .o_in_range  (w_in_range),
        .o_last_elem (w_last_elem),
        .o_last_win  (w_last_win),
        .o_addr      (w_addr),
        .o_oy        (w_oy),
        .o_ox        (w_ox)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_tag       <= 1'b0;
            r_out_data  <= '0;
            r_out_row   <= '0;
            r_out_col   <= '0;
        end else begin
            r_tag  <= w_rd_en;
            r_acc  <= w_acc_next;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= ISSUE;
                        r_busy  <= 1'b1;
                        r_acc   <= ACC_INIT;
                    end
                end
                ISSUE: begin
                    if (w_last_elem) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Last read returns this cycle, so the result folds it in directly.
                    r_out_data  <= w_acc_next;
                    r_out_row   <= w_oy;
                    r_out_col   <= w_ox;
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= ACC_INIT;
                        if (w_last_win) begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ISSUE;
                        end
                    end
                end
                FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.rd_en     = w_rd_en;
    assign bus.rd_addr   = w_rd_en ? w_addr : '0;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_row   = r_out_row;
    assign bus.out_col   = r_out_col;

endmodule

// File: tb/tb_pool_window_sched.sv
// Scoreboard bench for pool_window_sched: two instances (4x4/2x2/S2/P0 and 3x3/3x3/S1/P1).
module tb_pool_window_sched;
    import pool_pkg::*;

    typedef struct {
        int data;
        int row;
        int col;
        int reads;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pool_window_sched_if #(.DATA_W(8), .ADDR_W(4), .ROW_W(1), .COL_W(1)) ifA ();
    pool_window_sched_if #(.DATA_W(8), .ADDR_W(4), .ROW_W(2), .COL_W(2)) ifB ();

    pool_window_sched #(
        .DATA_W(8), .IN_W(4), .IN_H(4), .F_W(2), .F_H(2), .S(2), .P(0), .ADDR_W(4)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifA)
    );

    pool_window_sched #(
        .DATA_W(8), .IN_W(3), .IN_H(3), .F_W(3), .F_H(3), .S(1), .P(1), .ADDR_W(4)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifB)
    );

    exp_t                expq[2][$];
    logic signed [7:0]   mem[2][16];
    int                  tests = 0;
    int                  fails = 0;
    bit                  seen[2];
    int                  hd[2], hr[2], hc[2];
    int                  rcnt[2];
    int                  donecnt[2];
    int                  mode[2];
    int                  stallc[2];
    bit                  pend_en[2];
    int                  pend_addr[2];

    task automatic chk(string nm, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void cfg(int id, output int inw, output int inh, output int fw,
                                output int fh, output int s, output int p);
        if (id == 0) begin
            inw = 4; inh = 4; fw = 2; fh = 2; s = 2; p = 0;
        end else begin
            inw = 3; inh = 3; fw = 3; fh = 3; s = 1; p = 1;
        end
    endfunction

    // Reference: every output position, max over in-range window samples, plus read count.
    function automatic void model(int id);
        int inw, inh, fw, fh, s, p, ow, oh;
        cfg(id, inw, inh, fw, fh, s, p);
        ow = out_dim(inw, p, fw, s);
        oh = out_dim(inh, p, fh, s);
        for (int oy = 0; oy < oh; oy++) begin
            for (int ox = 0; ox < ow; ox++) begin
                int m = -128;
                int n = 0;
                for (int ky = 0; ky < fh; ky++) begin
                    for (int kx = 0; kx < fw; kx++) begin
                        int iy = oy * s + ky - p;
                        int ix = ox * s + kx - p;
                        if (iy >= 0 && iy < inh && ix >= 0 && ix < inw) begin
                            n++;
                            if (int'(mem[id][iy * inw + ix]) > m) m = int'(mem[id][iy * inw + ix]);
                        end
                    end
                end
                expq[id].push_back('{m, oy, ox, n});
            end
        end
    endfunction

    function automatic bit get_busy(int id);
        return (id == 0) ? ifA.busy : ifB.busy;
    endfunction

    function automatic bit get_done(int id);
        return (id == 0) ? ifA.done : ifB.done;
    endfunction

    function automatic int outs(int id);
        if (id == 0)
            return int'({ifA.busy, ifA.done, ifA.rd_en, ifA.out_valid, ifA.rd_addr,
                         ifA.out_data, ifA.out_row, ifA.out_col});
        return int'({ifB.busy, ifB.done, ifB.rd_en, ifB.out_valid, ifB.rd_addr,
                     ifB.out_data, ifB.out_row, ifB.out_col});
    endfunction

    task automatic set_start(int id, bit v);
        if (id == 0) ifA.start = v;
        else ifB.start = v;
    endtask

    task automatic mon(int id, bit valid, int data, int row, int col, bit rden, bit done, bit rstv);
        exp_t e;
        if (rstv) begin
            seen[id] = 0;
            rcnt[id] = 0;
            stallc[id] = 0;
            return;
        end
        if (done) donecnt[id]++;
        if (valid) begin
            tests++;
            if (rden) begin
                fails++;
                $display("FAIL rd_en_while_out[%0d]: got 1 expected 0", id);
            end
            if (!seen[id]) begin
                seen[id] = 1;
                hd[id] = data; hr[id] = row; hc[id] = col;
                tests++;
                if (expq[id].size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_result[%0d]: got data=%0d row=%0d col=%0d, expected none",
                             id, data, row, col);
                end else begin
                    e = expq[id].pop_front();
                    if (data !== e.data || row !== e.row || col !== e.col || rcnt[id] !== e.reads) begin
                        fails++;
                        $display("FAIL result[%0d]: got data=%0d row=%0d col=%0d reads=%0d, expected data=%0d row=%0d col=%0d reads=%0d",
                                 id, data, row, col, rcnt[id], e.data, e.row, e.col, e.reads);
                    end
                end
                rcnt[id] = 0;
            end else begin
                tests++;
                if (data !== hd[id] || row !== hr[id] || col !== hc[id]) begin
                    fails++;
                    $display("FAIL stall_hold[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d",
                             id, data, row, col, hd[id], hr[id], hc[id]);
                end
            end
        end else begin
            seen[id] = 0;
            if (rden) rcnt[id]++;
        end
    endtask

    function automatic bit next_ready(int id, bit valid);
        case (mode[id])
            0: return 1'b1;
            1: return ($urandom_range(0, 2) != 0);
            default: begin
                if (!valid) begin
                    stallc[id] = 0;
                    return 1'b0;
                end
                stallc[id]++;
                return (stallc[id] > 10);
            end
        endcase
    endfunction

    always @(negedge clk) begin
        mon(0, ifA.out_valid, int'(ifA.out_data), int'(ifA.out_row), int'(ifA.out_col),
            ifA.rd_en, ifA.done, rst);
        ifA.out_ready = next_ready(0, ifA.out_valid);
    end

    always @(negedge clk) begin
        mon(1, ifB.out_valid, int'(ifB.out_data), int'(ifB.out_row), int'(ifB.out_col),
            ifB.rd_en, ifB.done, rst);
        ifB.out_ready = next_ready(1, ifB.out_valid);
    end

    // Feature buffer: one-cycle read latency, garbage on cycles without a read.
    always @(negedge clk) begin
        pend_en[0] = ifA.rd_en; pend_addr[0] = int'(ifA.rd_addr);
        pend_en[1] = ifB.rd_en; pend_addr[1] = int'(ifB.rd_addr);
    end

    always @(posedge clk) begin
        ifA.rd_data <= pend_en[0] ? mem[0][pend_addr[0]] : 8'($urandom);
        ifB.rd_data <= pend_en[1] ? mem[1][pend_addr[1]] : 8'($urandom);
    end

    task automatic fill_addr(int id);
        for (int k = 0; k < 16; k++) mem[id][k] = 8'(k);
    endtask

    task automatic fill_const(int id, int v);
        for (int k = 0; k < 16; k++) mem[id][k] = 8'(v);
    endtask

    task automatic fill_rand(int id);
        for (int k = 0; k < 16; k++) mem[id][k] = 8'($urandom);
    endtask

    task automatic run(int id, int md, bit extra);
        int d0;
        bit got;
        mode[id] = md;
        model(id);
        d0 = donecnt[id];
        got = 0;
        @(negedge clk); set_start(id, 1'b1);
        @(negedge clk); set_start(id, 1'b0);
        chk($sformatf("busy_after_start[%0d]", id), int'(get_busy(id)), 1);
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk);
            if (get_done(id)) begin
                got = 1;
                set_start(id, extra);
            end else begin
                set_start(id, extra && get_busy(id) && ($urandom_range(0, 4) == 0));
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL timeout[%0d]: got no done in 3000 cycles, expected done", id);
            expq[id].delete();
        end
        @(negedge clk); set_start(id, 1'b0);
        chk($sformatf("busy_after_done[%0d]", id), int'(get_busy(id)), 0);
        chk($sformatf("done_one_cycle[%0d]", id), int'(get_done(id)), 0);
        @(negedge clk);
        chk($sformatf("fin_start_ignored[%0d]", id), int'(get_busy(id)), 0);
        chk($sformatf("done_count[%0d]", id), donecnt[id] - d0, 1);
        chk($sformatf("results_left[%0d]", id), expq[id].size(), 0);
        mode[id] = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bit hit;
        ifA.start = 1'b0;
        ifB.start = 1'b0;
        fill_addr(0);
        fill_addr(1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs_a", outs(0), 0);
        chk("reset_outputs_b", outs(1), 0);
        rst = 1'b0;

        fill_addr(0);
        run(0, 0, 0);
        run(0, 2, 1);

        fill_const(1, -5);
        run(1, 0, 0);
        run(1, 2, 1);

        fill_rand(0);
        mem[0][0] = -8'sd3;   mem[0][1] = -8'sd100; mem[0][4] = -8'sd1; mem[0][5] = -8'sd7;
        mem[0][2] = 8'sd127;  mem[0][3] = -8'sd128; mem[0][6] = 8'sd0;  mem[0][7] = 8'sd127;
        run(0, 1, 1);

        for (int i = 0; i < 6; i++) begin
            fill_rand(i % 2);
            run(i % 2, int'($urandom_range(0, 2)), 1'b1);
        end

        // Abort during the second window, then a clean rerun.
        fill_addr(0);
        mode[0] = 0;
        model(0);
        d0 = donecnt[0];
        hit = 0;
        @(negedge clk); ifA.start = 1'b1;
        @(negedge clk); ifA.start = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            if (expq[0].size() == 3 && ifA.rd_en) hit = 1;
        end
        chk("reached_second_window", int'(hit), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_midrun_outputs", outs(0), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", outs(0), 0);
        chk("no_done_after_abort", donecnt[0] - d0, 0);
        expq[0].delete();
        repeat (2) @(negedge clk);
        run(0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pool_window_sched.md
Name: pool_window_sched

Overview:
- Controller and scheduler for the max-pooling stage.
- On start, walks every output position of one feature-map channel in row-major order and issues reads for each window element to the feature buffer.
- Reduces returned samples to a running signed maximum and emits one pooled result per window on a valid/ready stream.
- Sits between the conv-output feature buffer and the next-layer input buffer; replaces hard-wired flattened-bus pooling for maps too large to present in parallel.

Parameters:
- DATA_W, 8, signed sample width
- IN_W, 8, input map width
- IN_H, 8, input map height
- F_W, 2, window width
- F_H, 2, window height
- S, 2, stride (both axes, >=1)
- P, 0, zero-area padding per side (padded positions never win the max)
- ADDR_W, $clog2(IN_W*IN_H), feature buffer address width

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle pulse, begin a channel
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last output accepted
- rd_en  out  1  feature buffer read strobe
- rd_addr  out  ADDR_W  read address = iy*IN_W+ix
- rd_data  in  DATA_W  buffer data, valid exactly 1 cycle after rd_en
- out_valid  out  1  pooled result valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_W  pooled max (signed)
- out_row  out  $clog2(OUT_H)  output row of out_data
- out_col  out  $clog2(OUT_W)  output column of out_data

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: every output is 0; FSM goes to IDLE. Applying rst mid-operation abandons the channel: no done, in-flight read data discarded.
- Derived constants: OUT_W=(IN_W+2P-F_W)/S+1 and OUT_H=(IN_H+2P-F_H)/S+1 (integer division). KN=F_W*F_H.
- FSM states: IDLE, ISSUE, DRAIN, OUT, FIN.
- IDLE: on start go to ISSUE with oy=ox=ky=kx=0 and acc=-2^(DATA_W-1); busy=1 from the next cycle. start is ignored when not in IDLE.
- ISSUE: one window element per cycle, kx fastest then ky. iy=oy*S+ky-P, ix=ox*S+kx-P.
  - In range: rd_en=1 and a tag pipe bit set.
  - Out of range (padding): rd_en=0 and no acc update.
  - After element KN-1 go to DRAIN.
- Accumulate: one cycle after a tagged read, acc <= max(acc, rd_data) using signed compare; ties keep acc.
- DRAIN: one cycle, absorbs the last read return. Then go to OUT with out_data=acc, out_row=oy, out_col=ox, out_valid=1.
- OUT: out_valid, out_data, out_row and out_col hold stable until out_ready. On the out_valid&&out_ready cycle:
  - advance ox (wrap to 0 and advance oy) and reset acc;
  - go to ISSUE, or to FIN if the accepted output was (OUT_H-1, OUT_W-1).
  - out_valid is low the cycle after acceptance; there is no overlap of windows.
- FIN: done=1 for one cycle, busy=0, back to IDLE. A start in the FIN cycle is ignored.
- Timing: window latency is KN issue cycles + 1 drain cycle, so out_valid rises KN+1 cycles after the window's first ISSUE cycle. Throughput is one window per KN+2 cycles at out_ready=1.
- A window that is entirely padding outputs -2^(DATA_W-1). This cannot occur when P<F_W and P<F_H; the parameter check is an elaboration-time assertion.

Decomposition:
- Shared package pool_pkg holds:
  - function out_dim(in,p,f,s);
  - the state enum type pool_state_t;
  - the constant SMIN(DATA_W).
- One natural sub-module: pool_addr_gen (counters oy/ox/ky/kx, in-range check, rd_addr multiply-add). The FSM, accumulator and output register stay in the top.

Test Plan:
- IN 4x4, F 2x2, S=2, P=0, buffer word = address value -> outputs (0,0)=5, (0,1)=7, (1,0)=13, (1,1)=15; done once; 4 rd_en per window, 16 total.
- IN 3x3, F 3x3, S=1, P=1, all samples -5 -> 9 outputs all -5 (not -128); corner window issues exactly 4 reads, centre window 9.
- Signed data: window {-3,-100,-1,-7} -> -1; window {127,-128,0,127} -> 127.
- 4x4/2x2/S2 with out_ready low for 10 cycles on each result -> out_data/row/col stable while stalled, no extra rd_en during stall, same 4 values.
- start pulsed while busy, and in the FIN cycle -> ignored; exactly one done; busy falls the cycle after done.
- rst asserted during the second window's ISSUE -> next cycle all outputs 0 and state IDLE. A new start produces the full correct sequence, beginning at (0,0)=5.
